// File: rtl/shared_countdown_pkg.sv
// Shared types, defaults and the round-robin search used by shared_countdown_arbiter.
// The search helper is purely combinational; it only looks at the low n request bits.
package shared_countdown_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int CNT_W_DEF   = 8;
  localparam int MAX_REQ     = 32;

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  // First set bit of req at or after last+1, wrapping modulo n; returns last when req is empty.
  function automatic int rr_next(input logic [MAX_REQ-1:0] req, input int n, input int last);
    int   idx;
    logic found;
    rr_next = last;
    found   = 1'b0;
    idx     = 0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      if (k <= n && !found) begin
        idx = last + k;
        if (idx >= n) idx = idx - n;
        if (req[idx]) begin
          rr_next = idx;
          found   = 1'b1;
        end
      end
    end
  endfunction

endpackage

// File: rtl/ld_down_counter.sv
// Loadable down-counter that saturates at zero; clr beats load beats en.
// One-cycle latency from any control input to count; zero is decoded from the register.
module ld_down_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end else if (en && count_q != '0) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/shared_countdown_arbiter.sv
// Round-robin owner of one shared down-counter; grant, countdown of load_val, one-cycle done.
// Owner holds the counter for N+2 cycles; new requests wait until IDLE, dropping req aborts.
module shared_countdown_arbiter
  import shared_countdown_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] load_val,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     busy,
  output logic [CNT_W-1:0]         count,
  output logic [NUM_REQ-1:0]       done
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t             state_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [NUM_REQ-1:0] done_q;
  logic               busy_q;
  logic [PTR_W-1:0]   ptr_q;

  logic [PTR_W-1:0]   win_d;
  logic [CNT_W-1:0]   win_val_d;
  logic               owner_req;
  logic               cnt_load;
  logic               cnt_en;
  logic               cnt_clr;
  logic               cnt_zero;

  always_comb begin
    win_d     = PTR_W'(rr_next(MAX_REQ'(req), NUM_REQ, int'(ptr_q)));
    win_val_d = load_val[int'(win_d)*CNT_W +: CNT_W];
    owner_req = |(req & gnt_q);
    cnt_load  = (state_q == IDLE) && (|req);
    cnt_en    = (state_q == COUNT) && owner_req;
    // Abort and the DONE->IDLE hop both leave the counter at zero for the next owner.
    cnt_clr   = ((state_q == COUNT) && !owner_req) || (state_q == DONE);
  end

  ld_down_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (win_val_d),
    .en       (cnt_en),
    .clr      (cnt_clr),
    .count    (count),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      ptr_q   <= PTR_W'(NUM_REQ - 1);
    end else begin
      case (state_q)
        IDLE: begin
          if (|req) begin
            state_q <= COUNT;
            gnt_q   <= NUM_REQ'(1) << win_d;
            busy_q  <= 1'b1;
            ptr_q   <= win_d;
          end
        end
        COUNT: begin
          if (!owner_req) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (cnt_zero) begin
            state_q <= DONE;
            done_q  <= gnt_q;
          end
        end
        DONE: begin
          state_q <= IDLE;
          gnt_q   <= '0;
          done_q  <= '0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
          done_q  <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt  = gnt_q;
  assign done = done_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_shared_countdown_arbiter.sv
// Bench for shared_countdown_arbiter: directed scenarios then random traffic against an ownership-timeline model.
module tb_shared_countdown_arbiter;

  localparam int NR = 4;
  localparam int CW = 8;

  logic              clk      = 1'b0;
  logic              reset    = 1'b0;
  logic [NR-1:0]     req      = '0;
  logic [NR*CW-1:0]  load_val = '0;
  logic [NR-1:0]     gnt;
  logic              busy;
  logic [CW-1:0]     count;
  logic [NR-1:0]     done;

  int n_vec = 0;
  int n_bad = 0;

  // Model: who owns the counter, its programmed length, and how many cycles it has held it (1 = grant cycle).
  int m_owner = -1;
  int m_age   = 0;
  int m_len   = 0;
  int m_last  = NR - 1;

  shared_countdown_arbiter #(.NUM_REQ(NR), .CNT_W(CW)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .load_val (load_val),
    .gnt      (gnt),
    .busy     (busy),
    .count    (count),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int lv_of(input int i);
    logic [CW-1:0] v;
    v = load_val[i*CW +: CW];
    return int'(v);
  endfunction

  task automatic set_lv(input int i, input int v);
    load_val[i*CW +: CW] = CW'(v);
  endtask

  task automatic model_edge();
    if (!reset) begin
      m_owner = -1;
      m_last  = NR - 1;
    end else if (m_owner < 0) begin
      if (req != '0) begin
        for (int k = 1; k <= NR; k++) begin
          int w;
          w = (m_last + k) % NR;
          if (req[w]) begin
            m_owner = w;
            m_len   = lv_of(w);
            m_age   = 1;
            m_last  = w;
            break;
          end
        end
      end
    end else if (m_age <= m_len + 1 && !req[m_owner]) begin
      m_owner = -1;
    end else if (m_age == m_len + 2) begin
      m_owner = -1;
    end else begin
      m_age++;
    end
  endtask

  task automatic step(input logic rst_v, input logic [NR-1:0] rq);
    int e_g, e_c, e_d, e_b;
    reset = rst_v;
    req   = rq;
    @(posedge clk);
    model_edge();
    #1;
    if (m_owner < 0) begin
      e_g = 0; e_c = 0; e_d = 0; e_b = 0;
    end else begin
      e_g = 1 << m_owner;
      e_b = 1;
      e_c = (m_age - 1 >= m_len) ? 0 : m_len - (m_age - 1);
      e_d = (m_age == m_len + 2) ? e_g : 0;
    end
    chk("gnt",   32'(gnt),   32'(e_g));
    chk("busy",  32'(busy),  32'(e_b));
    chk("count", 32'(count), 32'(e_c));
    chk("done",  32'(done),  32'(e_d));
  endtask

  initial begin
    logic [NR-1:0] rq;

    // Reset held with all requesting, then contention with unit lengths.
    for (int i = 0; i < NR; i++) set_lv(i, 1);
    step(1'b0, 4'b1111);
    step(1'b0, 4'b1111);
    for (int i = 0; i < 20; i++) step(1'b1, 4'b1111);
    for (int i = 0; i < 4; i++) step(1'b1, 4'b0000);

    // Single requester, length 3.
    set_lv(0, 3);
    for (int i = 0; i < 6; i++) step(1'b1, 4'b0001);
    for (int i = 0; i < 2; i++) step(1'b1, 4'b0000);

    // Zero length.
    set_lv(2, 0);
    for (int i = 0; i < 3; i++) step(1'b1, 4'b0100);
    for (int i = 0; i < 2; i++) step(1'b1, 4'b0000);

    // Abort at count 5, pending requester 1 then takes over.
    set_lv(2, 10);
    set_lv(1, 2);
    for (int i = 0; i < 6; i++) step(1'b1, 4'b0100);
    set_lv(2, 99);
    for (int i = 0; i < 6; i++) step(1'b1, 4'b0010);
    for (int i = 0; i < 2; i++) step(1'b1, 4'b0000);

    // Reset mid-count restores the pointer.
    set_lv(3, 8);
    set_lv(0, 1);
    for (int i = 0; i < 5; i++) step(1'b1, 4'b1000);
    step(1'b0, 4'b1000);
    for (int i = 0; i < 6; i++) step(1'b1, 4'b1001);
    for (int i = 0; i < 2; i++) step(1'b1, 4'b0000);

    // Random traffic: sticky requests, occasional drops and resets, load values churning every cycle.
    rq = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (rq[i]) rq[i] = ($urandom_range(0, 15) != 0);
        else       rq[i] = ($urandom_range(0, 3) == 0);
        set_lv(i, ($urandom_range(0, 19) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 6));
      end
      step(($urandom_range(0, 99) != 0), rq);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
